// File: rtl/hh_spike_detector_pkg.sv
// Shared voltage-format constants and FSM state type for the HH neuron tile.
// Voltages are signed Q9.5: code = mV * 32.
package hh_pkg;

    localparam int HH_W      = 14;
    localparam int HH_FRAC   = 5;

    localparam int V_REST    = -2080;
    localparam int THRESH_HI = 0;
    localparam int THRESH_LO = -640;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        ABOVE   = 2'd1,
        REFRACT = 2'd2
    } state_t;

endpackage

// File: rtl/hh_spike_detector_if.sv
// Sample/statistics bundle between the neuron-side driver and the spike detector.
// master drives samples and controls; slave (the detector) returns registered results.
interface hh_spike_detector_if #(
    parameter int W     = 14,
    parameter int CNT_W = 16,
    parameter int ISI_W = 16
) ();

    logic signed [W-1:0] v_in;
    logic                v_valid;
    logic                enable;
    logic                clear;
    logic                spike;
    logic [CNT_W-1:0]    spike_count;
    logic signed [W-1:0] peak_v;
    logic [ISI_W-1:0]    isi;
    logic                isi_valid;

    modport master (
        output v_in, v_valid, enable, clear,
        input  spike, spike_count, peak_v, isi, isi_valid
    );

    modport slave (
        input  v_in, v_valid, enable, clear,
        output spike, spike_count, peak_v, isi, isi_valid
    );

endinterface

// File: rtl/hh_spike_detector_sat_counter.sv
// Saturating up-counter: clear/load_zero zero the base value, inc then adds one unless at all-ones.
// Registered output, one-cycle update; sat reflects the current register value.
module hh_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    input  logic             load_zero,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] cnt_d;

    // A clear coinciding with an increment yields one, so the event that
    // shares the cycle with the clear is still counted.
    always_comb begin
        base  = (clear | load_zero) ? '0 : cnt_q;
        cnt_d = base;
        if (inc && !(&base)) begin
            cnt_d = base + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/hh_spike_detector.sv
// Action-potential detector with hysteresis and refractory window; spike count, peak and ISI stats.
// All outputs registered, 1 cycle after the triggering accepted sample.
module hh_spike_detector #(
    parameter int W           = hh_pkg::HH_W,
    parameter int THRESH_HI   = hh_pkg::THRESH_HI,
    parameter int THRESH_LO   = hh_pkg::THRESH_LO,
    parameter int REFRACT_CYC = 16,
    parameter int CNT_W       = 16,
    parameter int ISI_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    hh_spike_detector_if.slave bus
);

    import hh_pkg::*;

    localparam int REF_W = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
    localparam logic signed [W-1:0] TH_HI = W'(THRESH_HI);
    localparam logic signed [W-1:0] TH_LO = W'(THRESH_LO);

    state_t              state_q, state_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic signed [W-1:0] run_q, run_d;
    logic signed [W-1:0] peak_q, peak_d;

    logic accepted;
    logic above_hi;
    logic below_lo;
    logic spike_hit;

    assign accepted = bus.v_valid & bus.enable;
    assign above_hi = (bus.v_in >= TH_HI);
    assign below_lo = (bus.v_in < TH_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARMED;
            ref_q   <= '0;
            run_q   <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            run_q   <= run_d;
            peak_q  <= peak_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        run_d     = run_q;
        peak_d    = peak_q;
        spike_hit = 1'b0;
        if (accepted) begin
            case (state_q)
                ARMED: begin
                    if (above_hi) begin
                        spike_hit = 1'b1;
                        state_d   = ABOVE;
                        run_d     = bus.v_in;
                    end
                end
                ABOVE: begin
                    if (above_hi) begin
                        if (bus.v_in > run_q) begin
                            run_d = bus.v_in;
                        end
                    end else begin
                        peak_d  = run_q;
                        ref_d   = REF_W'(REFRACT_CYC - 1);
                        state_d = REFRACT;
                    end
                end
                REFRACT: begin
                    // Samples during the countdown are ignored; after it, re-arm needs a dip below THRESH_LO.
                    if (ref_q != '0) begin
                        ref_d = ref_q - REF_W'(1);
                    end else if (below_lo) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    logic [CNT_W-1:0] count;
    logic             count_sat;
    logic [ISI_W-1:0] timer;
    logic             timer_sat;
    logic [ISI_W-1:0] isi_next;

    hh_sat_counter #(.WIDTH(CNT_W)) u_spike_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (spike_hit & (bus.clear | ~count_sat)),
        .clear     (bus.clear),
        .load_zero (1'b0),
        .cnt       (count),
        .sat       (count_sat)
    );

    hh_sat_counter #(.WIDTH(ISI_W)) u_isi_timer (
        .clk       (clk),
        .rst       (rst),
        .inc       (accepted & ~spike_hit),
        .clear     (bus.clear),
        .load_zero (spike_hit),
        .cnt       (timer),
        .sat       (timer_sat)
    );

    // Timer counts non-spike samples since the last spike, so the interval is timer+1.
    assign isi_next = timer_sat ? timer : timer + ISI_W'(1);

    logic             spike_q;
    logic             isi_valid_q;
    logic [ISI_W-1:0] isi_q;
    logic             have_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q     <= 1'b0;
            isi_valid_q <= 1'b0;
            isi_q       <= '0;
            have_prev_q <= 1'b0;
        end else begin
            spike_q     <= spike_hit;
            isi_valid_q <= spike_hit & have_prev_q & ~bus.clear;
            if (bus.clear) begin
                isi_q <= '0;
            end else if (spike_hit & have_prev_q) begin
                isi_q <= isi_next;
            end
            if (spike_hit) begin
                have_prev_q <= 1'b1;
            end else if (bus.clear) begin
                have_prev_q <= 1'b0;
            end
        end
    end

    assign bus.spike       = spike_q;
    assign bus.spike_count = count;
    assign bus.peak_v      = peak_q;
    assign bus.isi         = isi_q;
    assign bus.isi_valid   = isi_valid_q;

endmodule

// File: tb/tb_hh_spike_detector.sv
// Two detector instances (default and small REFRACT/CNT/ISI widths) driven in lockstep,
// checked against a behavioural scoreboard plus directed values.
module tb_hh_spike_detector;

    import hh_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hh_spike_detector_if #(.W(14), .CNT_W(16), .ISI_W(16)) b0 ();
    hh_spike_detector_if #(.W(14), .CNT_W(4),  .ISI_W(4))  b1 ();

    hh_spike_detector #(
        .W(14), .THRESH_HI(0), .THRESH_LO(-640), .REFRACT_CYC(16), .CNT_W(16), .ISI_W(16)
    ) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    hh_spike_detector #(
        .W(14), .THRESH_HI(0), .THRESH_LO(-640), .REFRACT_CYC(4), .CNT_W(4), .ISI_W(4)
    ) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        int spike;
        int cnt;
        int pk;
        int isi;
        int isiv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int ncmp = 0;
    int nerr = 0;

    int REF [2] = '{16, 4};
    int CMAX[2] = '{65535, 15};
    int IMAX[2] = '{65535, 15};

    int ms[2], mcnt[2], mrun[2], mpk[2], misi[2], mtim[2], mhp[2], mref[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mcnt[i] = 0; mrun[i] = 0; mpk[i] = 0;
            misi[i] = 0; mtim[i] = 0; mhp[i] = 0; mref[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model(input int i, input int v, input bit vld, input bit en,
                         input bit clr, output exp_t e);
        bit acc;
        bit sp;
        acc = vld & en;
        sp  = 1'b0;
        if (acc) begin
            case (ms[i])
                0: if (v >= 0) begin sp = 1'b1; ms[i] = 1; mrun[i] = v; end
                1: begin
                    if (v >= 0) begin
                        if (v > mrun[i]) mrun[i] = v;
                    end else begin
                        mpk[i] = mrun[i]; mref[i] = REF[i] - 1; ms[i] = 2;
                    end
                end
                default: begin
                    if (mref[i] != 0) mref[i] = mref[i] - 1;
                    else if (v < -640) ms[i] = 0;
                end
            endcase
        end
        e.isiv = (sp && mhp[i] != 0 && !clr) ? 1 : 0;
        if (e.isiv != 0) misi[i] = (mtim[i] + 1 > IMAX[i]) ? IMAX[i] : mtim[i] + 1;
        if (clr) begin
            mcnt[i] = 0; misi[i] = 0; mtim[i] = 0; mhp[i] = 0;
        end
        if (sp) begin
            if (mcnt[i] < CMAX[i]) mcnt[i] = mcnt[i] + 1;
            mtim[i] = 0;
            mhp[i]  = 1;
        end else if (acc && mtim[i] < IMAX[i]) begin
            mtim[i] = mtim[i] + 1;
        end
        e.spike = sp ? 1 : 0;
        e.cnt   = mcnt[i];
        e.pk    = mpk[i];
        e.isi   = misi[i];
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic score();
        exp_t e;
        e = q0.pop_front();
        chk("d0_spike",     int'(b0.spike),       e.spike);
        chk("d0_count",     int'(b0.spike_count), e.cnt);
        chk("d0_peak",      int'(b0.peak_v),      e.pk);
        chk("d0_isi",       int'(b0.isi),         e.isi);
        chk("d0_isi_valid", int'(b0.isi_valid),   e.isiv);
        e = q1.pop_front();
        chk("d1_spike",     int'(b1.spike),       e.spike);
        chk("d1_count",     int'(b1.spike_count), e.cnt);
        chk("d1_peak",      int'(b1.peak_v),      e.pk);
        chk("d1_isi",       int'(b1.isi),         e.isi);
        chk("d1_isi_valid", int'(b1.isi_valid),   e.isiv);
    endtask

    task automatic step(input int v, input bit vld = 1'b1, input bit en = 1'b1,
                        input bit clr = 1'b0);
        exp_t e;
        b0.v_in = 14'(v); b0.v_valid = vld; b0.enable = en; b0.clear = clr;
        b1.v_in = 14'(v); b1.v_valid = vld; b1.enable = en; b1.clear = clr;
        model(0, v, vld, en, clr, e);
        q0.push_back(e);
        model(1, v, vld, en, clr, e);
        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
        score();
    endtask

    initial begin
        b0.v_in = '0; b0.v_valid = 1'b0; b0.enable = 1'b1; b0.clear = 1'b0;
        b1.v_in = '0; b1.v_valid = 1'b0; b1.enable = 1'b1; b1.clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Build up non-zero state, then reset asynchronously between edges.
        step(-2080); step(160); step(960); step(-960);
        chk("pre_rst_count", int'(b0.spike_count), 1);
        chk("pre_rst_peak",  int'(b0.peak_v), 960);
        #2 rst = 1'b1;
        #1;
        chk("rst_spike",     int'(b0.spike), 0);
        chk("rst_count",     int'(b0.spike_count), 0);
        chk("rst_peak",      int'(b0.peak_v), 0);
        chk("rst_isi",       int'(b0.isi), 0);
        chk("rst_isi_valid", int'(b0.isi_valid), 0);
        chk("rst_state0",    int'(dut0.state_q), int'(ARMED));
        chk("rst_state1",    int'(dut1.state_q), int'(ARMED));
        chk("rst_count1",    int'(b1.spike_count), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(-2080); step(-2080);

        // Single spike
        step(-2080); step(-320);
        step(160);
        chk("single_spike", int'(b0.spike), 1);
        step(960); step(320);
        step(-960);
        chk("single_peak",  int'(b0.peak_v), 960);
        chk("single_count", int'(b0.spike_count), 1);

        // Refractory and hysteresis on the short-window instance
        step(64); step(-100); step(64); step(-800);
        chk("refr_no_early", int'(b1.spike), 0);
        step(160);
        chk("refr_spike",  int'(b1.spike), 1);
        chk("refr_count",  int'(b1.spike_count), 2);
        chk("refr_d0_off", int'(b0.spike), 0);

        // ISI: triggers 40 accepted samples apart with idle gaps
        repeat (20) step(-2080);
        step(160);
        for (int k = 1; k < 40; k++) begin
            step(0, 1'b0);
            step(-2080);
        end
        step(0, 1'b0);
        step(160);
        chk("isi_d0",       int'(b0.isi), 40);
        chk("isi_valid_d0", int'(b0.isi_valid), 1);
        chk("isi_d1_sat",   int'(b1.isi), 15);
        chk("isi_valid_d1", int'(b1.isi_valid), 1);
        step(-2080);
        chk("isi_pulse_d0", int'(b0.isi_valid), 0);
        chk("isi_pulse_d1", int'(b1.isi_valid), 0);

        // Saturation and clear coincident with a spike
        step(-2080, 1'b1, 1'b1, 1'b1);
        chk("clear_count", int'(b1.spike_count), 0);
        for (int s = 0; s < 17; s++) begin
            repeat (5) step(-2080);
            step(160);
        end
        chk("sat_count", int'(b1.spike_count), 15);
        repeat (5) step(-2080);
        step(160, 1'b1, 1'b1, 1'b1);
        chk("clr_spike",     int'(b1.spike), 1);
        chk("clr_count",     int'(b1.spike_count), 1);
        chk("clr_isi_valid", int'(b1.isi_valid), 0);
        chk("clr_isi",       int'(b1.isi), 0);

        // enable low freezes the detector
        repeat (20) step(-2080);
        repeat (3) begin
            step(960, 1'b1, 1'b0);
            chk("en_low_d0", int'(b0.spike), 0);
            chk("en_low_d1", int'(b1.spike), 0);
        end
        step(960);
        chk("en_high_d0", int'(b0.spike), 1);
        chk("en_high_d1", int'(b1.spike), 1);
        step(-2080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
